// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-port RAM arbiter.
// Optional build macro ARB_RR_EN (round-robin IDLE arbitration) is handled in ram_port_arbiter.
package ram_arb_pkg;

    localparam int ADDR_W_DEF   = 16;
    localparam int DATA_W_DEF   = 16;
    localparam int RD_LAT_DEF   = 1;
    localparam int MAX_LOCK_DEF = 16;
    localparam int LOCK_CNT_W   = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        LOCK1 = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } owner_t;

endpackage

// File: rtl/rd_track_pipe.sv
// RD_LAT-deep shift register of {valid, owner} tags for reads in flight.
// Shifts every cycle; the tail lines up with the RAM's read data.
module rd_track_pipe
    import ram_arb_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  owner_t push_owner,
    output logic   tail_valid,
    output owner_t tail_owner
);

    logic [RD_LAT-1:0] valid_reg;
    logic [RD_LAT-1:0] owner_reg;
    logic [RD_LAT:0]   valid_next;
    logic [RD_LAT:0]   owner_next;

    // Prepending the new entry in a wider vector keeps RD_LAT=1 legal.
    assign valid_next = {valid_reg, push};
    assign owner_next = {owner_reg, push_owner == OWNER_M1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= '0;
            owner_reg <= '0;
        end else begin
            valid_reg <= valid_next[RD_LAT-1:0];
            owner_reg <= owner_next[RD_LAT-1:0];
        end
    end

    assign tail_valid = valid_reg[RD_LAT-1];
    assign tail_owner = owner_reg[RD_LAT-1] ? OWNER_M1 : OWNER_M0;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between the CPU (m0) and DMA (m1), with bounded m1 bus lock.
// Build option: define ARB_RR_EN for round-robin IDLE arbitration (default: m0 fixed priority).
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RD_LAT   = RD_LAT_DEF,
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    input  logic              m1_lock,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              lock_timeout
);

    localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(MAX_LOCK - 1);

    arb_state_t              state_reg;
    logic [LOCK_CNT_W-1:0]   lock_cnt_reg;
    logic                    cool_reg;
    logic                    timeout_reg;
    logic [ADDR_W-1:0]       addr_hold_reg;
    logic                    push;
    owner_t                  push_owner;
    logic                    tail_valid;
    owner_t                  tail_owner;
    logic [1:0]              rvalid_vec;
    logic [DATA_W-1:0]       rdata_vec [2];

`ifdef ARB_RR_EN
    owner_t last_winner_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_winner_reg <= OWNER_M1;
        end else if (m0_gnt) begin
            last_winner_reg <= OWNER_M0;
        end else if (m1_gnt) begin
            last_winner_reg <= OWNER_M1;
        end
    end
`endif

    // The cycle right after a forced release always favours m0, in either build.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst) begin
            if (state_reg == LOCK1) begin
                m1_gnt = m1_req;
            end else if (m0_req && m1_req) begin
`ifdef ARB_RR_EN
                if (cool_reg || last_winner_reg == OWNER_M1) begin
                    m0_gnt = 1'b1;
                end else begin
                    m1_gnt = 1'b1;
                end
`else
                m0_gnt = 1'b1;
`endif
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = addr_hold_reg;
        ram_wdata = '0;
        if (m0_gnt) begin
            ram_we    = m0_we;
            ram_addr  = m0_addr;
            ram_wdata = m0_wdata;
        end else if (m1_gnt) begin
            ram_we    = m1_we;
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
        end
    end

    assign push       = (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
    assign push_owner = m1_gnt ? OWNER_M1 : OWNER_M0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            lock_cnt_reg  <= '0;
            cool_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
            addr_hold_reg <= '0;
        end else begin
            timeout_reg <= 1'b0;
            cool_reg    <= 1'b0;
            if (m0_gnt || m1_gnt) begin
                addr_hold_reg <= ram_addr;
            end
            case (state_reg)
                IDLE: begin
                    lock_cnt_reg <= '0;
                    if (m1_gnt && m1_lock && !cool_reg) begin
                        state_reg    <= LOCK1;
                        lock_cnt_reg <= LOCK_CNT_W'(1);
                    end
                end
                LOCK1: begin
                    if (!m1_lock) begin
                        state_reg    <= IDLE;
                        lock_cnt_reg <= '0;
                    end else if (lock_cnt_reg == LOCK_LAST) begin
                        // The grant cycle that entered the lock counted as lock cycle 1.
                        state_reg    <= IDLE;
                        lock_cnt_reg <= lock_cnt_reg + 1'b1;
                        timeout_reg  <= 1'b1;
                        cool_reg     <= 1'b1;
                    end else begin
                        lock_cnt_reg <= lock_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign lock_timeout = timeout_reg;

    rd_track_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_track_pipe (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_owner (push_owner),
        .tail_valid (tail_valid),
        .tail_owner (tail_owner)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_W-1:0] rdata_hold_reg;

            assign rvalid_vec[gi] = tail_valid && (tail_owner == ((gi == 0) ? OWNER_M0 : OWNER_M1));
            assign rdata_vec[gi]  = rvalid_vec[gi] ? ram_rdata : rdata_hold_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rdata_hold_reg <= '0;
                end else if (rvalid_vec[gi]) begin
                    rdata_hold_reg <= ram_rdata;
                end
            end
        end
    endgenerate

    assign m0_rvalid = rvalid_vec[0];
    assign m1_rvalid = rvalid_vec[1];
    assign m0_rdata  = rdata_vec[0];
    assign m1_rdata  = rdata_vec[1];

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a write-first RAM model (RD_LAT=2, MAX_LOCK=16).
module tb_ram_port_arbiter;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [15:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_lock;
    logic [15:0] m1_addr, m1_wdata, m1_rdata;
    logic        ram_we, lock_timeout;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;

    logic [15:0] mem [65536];
    logic [15:0] rd_pipe [RD_LAT];

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .RD_LAT   (RD_LAT),
        .MAX_LOCK (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m0_req       (m0_req),
        .m0_we        (m0_we),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_gnt       (m0_gnt),
        .m0_rvalid    (m0_rvalid),
        .m0_rdata     (m0_rdata),
        .m1_req       (m1_req),
        .m1_we        (m1_we),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_gnt       (m1_gnt),
        .m1_rvalid    (m1_rvalid),
        .m1_rdata     (m1_rdata),
        .m1_lock      (m1_lock),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .lock_timeout (lock_timeout)
    );

    // Write-first single-port RAM with RD_LAT cycles of read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        rd_pipe[0] <= ram_we ? ram_wdata : mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[RD_LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s = %h", tag, obs);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic lock);
        m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_lock = lock;
    endtask

    task automatic wr_m1(input logic [15:0] addr, input logic [15:0] data);
        set_m1(1'b1, 1'b1, addr, data, 1'b0);
        @(negedge clk);
        chk("preload_m1_gnt", m1_gnt, 1);
        chk("preload_ram_we", ram_we, 1);
        chk("preload_ram_wdata", ram_wdata, data);
        next_cycle();
        set_m1(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    int  g0, g1;
    logic exp0;

    initial begin
        rst = 1'b0;
        set_m0(1'b1, 1'b1, 16'h0001, 16'h1111);
        set_m1(1'b1, 1'b1, 16'h0002, 16'h2222, 1'b1);
        @(negedge clk);
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_lock_timeout", lock_timeout, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m0_rdata", m0_rdata, 16'h0);
        chk("rst_ram_addr", ram_addr, 16'h0);
        set_m0(1'b0, 1'b0, 16'h0, 16'h0);
        set_m1(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        next_cycle();
        rst = 1'b1;
        next_cycle();

        wr_m1(16'h0010, 16'hBEEF);
        wr_m1(16'h0020, 16'h1234);
        wr_m1(16'h0030, 16'h5A5A);
        @(negedge clk);
        chk("idle_ram_we", ram_we, 0);
        chk("idle_ram_addr_hold", ram_addr, 16'h0030);
        chk("idle_ram_wdata", ram_wdata, 16'h0);
        next_cycle();

        // Single CPU read
        set_m0(1'b1, 1'b0, 16'h0010, 16'h0);
        @(negedge clk);
        chk("rd_m0_gnt", m0_gnt, 1);
        chk("rd_ram_addr", ram_addr, 16'h0010);
        next_cycle();
        set_m0(1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        chk("rd_m0_rvalid_early", m0_rvalid, 0);
        next_cycle();
        @(negedge clk);
        chk("rd_m0_rvalid", m0_rvalid, 1);
        chk("rd_m0_rdata", m0_rdata, 16'hBEEF);
        chk("rd_m1_rvalid", m1_rvalid, 0);
        next_cycle();
        @(negedge clk);
        chk("rd_m0_rvalid_after", m0_rvalid, 0);
        chk("rd_m0_rdata_held", m0_rdata, 16'hBEEF);
        next_cycle();

        // Interleaved reads: m0 then m1 on consecutive cycles
        set_m0(1'b1, 1'b0, 16'h0030, 16'h0);
        @(negedge clk);
        chk("il_m0_gnt", m0_gnt, 1);
        next_cycle();
        set_m0(1'b0, 1'b0, 16'h0, 16'h0);
        set_m1(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0);
        @(negedge clk);
        chk("il_m1_gnt", m1_gnt, 1);
        next_cycle();
        set_m1(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        chk("il_m0_rvalid", m0_rvalid, 1);
        chk("il_m0_rdata", m0_rdata, 16'h5A5A);
        chk("il_m1_rvalid_0", m1_rvalid, 0);
        next_cycle();
        @(negedge clk);
        chk("il_m1_rvalid", m1_rvalid, 1);
        chk("il_m1_rdata", m1_rdata, 16'h1234);
        chk("il_m0_rvalid_0", m0_rvalid, 0);
        next_cycle();

        // Conflict: both request for 4 cycles
        set_m0(1'b1, 1'b1, 16'h0040, 16'h4444);
        set_m1(1'b1, 1'b1, 16'h0050, 16'h5555, 1'b0);
        g0 = 0;
        g1 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
`ifdef ARB_RR_EN
            exp0 = (i % 2 == 0);
`else
            exp0 = 1'b1;
`endif
            chk("conflict_m0_gnt", m0_gnt, exp0);
            chk("conflict_m1_gnt", m1_gnt, !exp0);
            g0 += int'(m0_gnt);
            g1 += int'(m1_gnt);
            next_cycle();
        end
`ifdef ARB_RR_EN
        chk("conflict_m0_total", g0, 2);
        chk("conflict_m1_total", g1, 2);
`else
        chk("conflict_m0_total", g0, 4);
        chk("conflict_m1_total", g1, 0);
`endif
        set_m0(1'b0, 1'b0, 16'h0, 16'h0);
        set_m1(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        next_cycle();

        // Lock burst: m1 writes 0x0100..0x0103
        set_m1(1'b1, 1'b1, 16'h0100, 16'hA000, 1'b1);
        @(negedge clk);
        chk("lk_m1_gnt0", m1_gnt, 1);
        next_cycle();
        set_m0(1'b1, 1'b1, 16'h0200, 16'h7777);
        for (int i = 1; i < 4; i++) begin
            set_m1(1'b1, 1'b1, 16'h0100 + 16'(i), 16'hA000 + 16'(i), 1'b1);
            @(negedge clk);
            chk("lk_m0_gnt", m0_gnt, 0);
            chk("lk_m1_gnt", m1_gnt, 1);
            next_cycle();
        end
        set_m1(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        chk("lk_m0_gnt_exit", m0_gnt, 0);
        next_cycle();
        @(negedge clk);
        chk("lk_m0_gnt_after", m0_gnt, 1);
        next_cycle();
        set_m0(1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) set_m1(1'b1, 1'b0, 16'h0100 + 16'(i), 16'h0, 1'b0);
            else       set_m1(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
            @(negedge clk);
            if (i >= 2) begin
                chk("lk_readback_rvalid", m1_rvalid, 1);
                chk("lk_readback_rdata", m1_rdata, 16'hA000 + 16'(i - 2));
            end
            next_cycle();
        end

        // Lock timeout
        set_m1(1'b1, 1'b1, 16'h0300, 16'h3333, 1'b1);
        @(negedge clk);
        chk("to_m1_gnt_entry", m1_gnt, 1);
        next_cycle();
        set_m0(1'b1, 1'b1, 16'h0400, 16'h1111);
        g1 = 1;
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            chk("to_m0_gnt_locked", m0_gnt, 0);
            chk("to_lock_timeout_low", lock_timeout, 0);
            g1 += int'(m1_gnt);
            next_cycle();
        end
        chk("to_m1_lock_cycles", g1, 16);
        @(negedge clk);
        chk("to_lock_timeout", lock_timeout, 1);
        chk("to_m0_gnt_release", m0_gnt, 1);
        chk("to_m1_gnt_release", m1_gnt, 0);
        next_cycle();
        set_m0(1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        chk("to_lock_timeout_pulse_end", lock_timeout, 0);
        chk("to_m1_gnt_relock", m1_gnt, 1);
        next_cycle();
        set_m0(1'b1, 1'b1, 16'h0400, 16'h1111);
        @(negedge clk);
        chk("to_m0_gnt_relocked", m0_gnt, 0);
        chk("to_m1_gnt_relocked", m1_gnt, 1);
        next_cycle();
        set_m1(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        chk("to_m0_gnt_unlock_cycle", m0_gnt, 0);
        next_cycle();
        @(negedge clk);
        chk("to_m0_gnt_idle", m0_gnt, 1);
        next_cycle();
        set_m0(1'b0, 1'b0, 16'h0, 16'h0);

        // Reset mid-read
        set_m0(1'b1, 1'b0, 16'h0010, 16'h0);
        @(negedge clk);
        chk("rr_m0_gnt", m0_gnt, 1);
        next_cycle();
        rst = 1'b0;
        set_m0(1'b1, 1'b0, 16'h0010, 16'h0);
        set_m1(1'b1, 1'b1, 16'h0011, 16'h9999, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rr_m0_gnt_in_rst", m0_gnt, 0);
            chk("rr_m1_gnt_in_rst", m1_gnt, 0);
            chk("rr_ram_we_in_rst", ram_we, 0);
            chk("rr_m0_rvalid_in_rst", m0_rvalid, 0);
            next_cycle();
        end
        set_m0(1'b0, 1'b0, 16'h0, 16'h0);
        set_m1(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rr_m0_rvalid_after", m0_rvalid, 0);
            chk("rr_m1_rvalid_after", m1_rvalid, 0);
            chk("rr_m0_rdata_cleared", m0_rdata, 16'h0);
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
